// File: rtl/decoder_2to4_reg_if.sv
// Select/enable bus into the registered decoder and its decoded outputs.
interface decoder_2to4_reg_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic [SEL_W-1:0] select;
  logic [OUT_W-1:0] out;
  logic             valid;
  logic             changed;

  modport master (output en, output select, input out, input valid, input changed);
  modport slave  (input en, input select, output out, output valid, output changed);
endinterface

// File: rtl/decoder_2to4_reg.sv
// Registered binary-to-one-hot (optionally one-cold) decoder with a sticky
// valid flag and a pulse marking cycles where the decoded value moved.

// One output bit: compares the select code against its own index.
module decoder_2to4_reg_lane #(
  parameter int IDX        = 0,
  parameter int SEL_W      = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] select,
  output logic             d,
  output logic             q
);
  localparam logic [SEL_W-1:0] CODE = SEL_W'(IDX);
  localparam logic             IDLE = 1'(ACTIVE_LOW);

  always_comb begin
    d = q;
    if (en) d = (select == CODE) ? ~IDLE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= IDLE;
    else     q <= d;
  end
endmodule

module decoder_2to4_reg #(
  parameter int SEL_W      = 2,
  parameter int ACTIVE_LOW = 0
) (
  input logic              clk,
  input logic              rst,
  decoder_2to4_reg_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;

  logic [OUT_W-1:0] d_vec;
  logic [OUT_W-1:0] q_vec;
  logic             valid_q;
  logic             changed_q;

  for (genvar k = 0; k < OUT_W; k++) begin : g_lane
    decoder_2to4_reg_lane #(
      .IDX        (k),
      .SEL_W      (SEL_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en),
      .select (bus.select),
      .d      (d_vec[k]),
      .q      (q_vec[k])
    );
  end

  // d_vec equals q_vec when en is low, so holding never raises changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      if (bus.en) valid_q <= 1'b1;
      changed_q <= (d_vec != q_vec);
    end
  end

  assign bus.out     = q_vec;
  assign bus.valid   = valid_q;
  assign bus.changed = changed_q;
endmodule

// File: tb/tb_decoder_2to4_reg.sv
// Directed bench for decoder_2to4_reg: one-hot build and one-cold build side by side.
module tb_decoder_2to4_reg;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decoder_2to4_reg_if #(.SEL_W(2)) bh ();
  decoder_2to4_reg_if #(.SEL_W(2)) bl ();

  decoder_2to4_reg #(.SEL_W(2), .ACTIVE_LOW(0)) dut_h (.clk(clk), .rst(rst), .bus(bh.slave));
  decoder_2to4_reg #(.SEL_W(2), .ACTIVE_LOW(1)) dut_l (.clk(clk), .rst(rst), .bus(bl.slave));

  task automatic drive(input logic r, input logic e, input logic [1:0] s);
    rst = r; bh.en = e; bh.select = s; bl.en = e; bl.select = s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 2'b01);
      checks++; if (bh.out !== 4'b0000) begin errors++; $display("FAIL reset_out cyc%0d got=%b exp=0000", i, bh.out); end
      checks++; if (bh.valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got=%b exp=0", i, bh.valid); end
      checks++; if (bh.changed !== 1'b0) begin errors++; $display("FAIL reset_changed cyc%0d got=%b exp=0", i, bh.changed); end
      checks++; if (bl.out !== 4'b1111) begin errors++; $display("FAIL reset_out_al cyc%0d got=%b exp=1111", i, bl.out); end
      checks++; if (bl.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_al cyc%0d got=%b exp=0", i, bl.valid); end
    end
  endtask

  task automatic test_idle_after_reset();
    drive(1'b0, 1'b0, 2'b10);
    checks++; if (bh.out !== 4'b0000) begin errors++; $display("FAIL idle_out got=%b exp=0000", bh.out); end
    checks++; if (bh.valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", bh.valid); end
    checks++; if (bh.changed !== 1'b0) begin errors++; $display("FAIL idle_changed got=%b exp=0", bh.changed); end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_h [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] exp_l [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'(i));
      checks++; if (bh.out !== exp_h[i]) begin errors++; $display("FAIL sweep_out sel=%0d got=%b exp=%b", i, bh.out, exp_h[i]); end
      checks++; if (bh.valid !== 1'b1) begin errors++; $display("FAIL sweep_valid sel=%0d got=%b exp=1", i, bh.valid); end
      checks++; if (bh.changed !== 1'b1) begin errors++; $display("FAIL sweep_changed sel=%0d got=%b exp=1", i, bh.changed); end
      checks++; if (bl.out !== exp_l[i]) begin errors++; $display("FAIL sweep_out_al sel=%0d got=%b exp=%b", i, bl.out, exp_l[i]); end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 2'd0);
    checks++; if (bh.out !== 4'b0001) begin errors++; $display("FAIL wrap_out0 got=%b exp=0001", bh.out); end
    checks++; if (bh.changed !== 1'b1) begin errors++; $display("FAIL wrap_changed0 got=%b exp=1", bh.changed); end
    drive(1'b0, 1'b1, 2'd1);
    checks++; if (bh.out !== 4'b0010) begin errors++; $display("FAIL wrap_out1 got=%b exp=0010", bh.out); end
    checks++; if (bh.changed !== 1'b1) begin errors++; $display("FAIL wrap_changed1 got=%b exp=1", bh.changed); end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 2'd2);
    checks++; if (bh.out !== 4'b0100) begin errors++; $display("FAIL hold_load got=%b exp=0100", bh.out); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'd1);
      checks++; if (bh.out !== 4'b0100) begin errors++; $display("FAIL hold_out cyc%0d got=%b exp=0100", i, bh.out); end
      checks++; if (bh.changed !== 1'b0) begin errors++; $display("FAIL hold_changed cyc%0d got=%b exp=0", i, bh.changed); end
      checks++; if (bh.valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc%0d got=%b exp=1", i, bh.valid); end
      checks++; if (bl.out !== 4'b1011) begin errors++; $display("FAIL hold_out_al cyc%0d got=%b exp=1011", i, bl.out); end
    end
  endtask

  task automatic test_repeat();
    logic exp_c [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'd3);
      checks++; if (bh.out !== 4'b1000) begin errors++; $display("FAIL repeat_out cyc%0d got=%b exp=1000", i, bh.out); end
      checks++; if (bh.changed !== exp_c[i]) begin errors++; $display("FAIL repeat_changed cyc%0d got=%b exp=%b", i, bh.changed, exp_c[i]); end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b1, 2'd3);
    checks++; if (bh.out !== 4'b0000) begin errors++; $display("FAIL midrst_out got=%b exp=0000", bh.out); end
    checks++; if (bh.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bh.valid); end
    checks++; if (bh.changed !== 1'b0) begin errors++; $display("FAIL midrst_changed got=%b exp=0", bh.changed); end
    checks++; if (bl.out !== 4'b1111) begin errors++; $display("FAIL midrst_out_al got=%b exp=1111", bl.out); end
    drive(1'b0, 1'b1, 2'd1);
    checks++; if (bh.out !== 4'b0010) begin errors++; $display("FAIL postrst_out got=%b exp=0010", bh.out); end
    checks++; if (bh.changed !== 1'b1) begin errors++; $display("FAIL postrst_changed got=%b exp=1", bh.changed); end
    checks++; if (bh.valid !== 1'b1) begin errors++; $display("FAIL postrst_valid got=%b exp=1", bh.valid); end
    checks++; if (bl.out !== 4'b1101) begin errors++; $display("FAIL postrst_out_al got=%b exp=1101", bl.out); end
    checks++; if (bl.changed !== 1'b1) begin errors++; $display("FAIL postrst_changed_al got=%b exp=1", bl.changed); end
  endtask

  initial begin
    rst = 1'b1; bh.en = 1'b0; bh.select = '0; bl.en = 1'b0; bl.select = '0;
    test_reset();
    test_idle_after_reset();
    test_reset();
    test_sweep();
    test_wrap();
    test_hold();
    test_repeat();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
